mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store access controller for the multi-cycle core. Sits between the core's execute/writeback control and the byte-addressable data memory, and drives that memory's address, data, write-enable, size and extend inputs. Checks range and alignment, splits misaligned accesses into byte accesses, assembles read data, applies sign/zero extension, and returns a single-cycle response to the core.

## Interface
Parameters:
- BUS_WIDTH, 32, data/address width
- MEM_BYTES, 128, memory size in bytes; valid addresses 0..MEM_BYTES-1
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = flag them as errors

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  core request strobe
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_size  in  2  00 byte, 01 half, 10 word, 11 invalid
- req_sext  in  1  load: 1 sign-extend, 0 zero-extend
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; range, size or alignment fault
- mem_address  out  32  memory byte address
- mem_data_in  out  32  memory write data
- mem_wr_en  out  1  memory write enable
- mem_size  out  2  memory access size
- mem_sz_ex  out  1  memory extend select
- mem_data_out  in  32  memory combinational read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* and evaluate the request. nbytes = 1/2/4, and end = req_addr + nbytes is computed in 33 bits with no wrap.
  - Error if req_size=11, or end > MEM_BYTES, or the access is misaligned with SPLIT_MISALIGNED=0. On error go to RESP with resp_err=1; no memory cycle is issued.
  - Otherwise go to ACCESS.
- Misaligned definition: half with addr[0]=1; word with addr[1:0]≠00. Bytes are never misaligned.
- ACCESS, aligned: one cycle.
  - Drive mem_address=addr, mem_size=req_size, mem_sz_ex=req_sext, mem_data_in=wdata, mem_wr_en=req_we.
  - Load: capture mem_data_out at the closing posedge, unmodified.
- ACCESS, split: nbytes cycles, byte counter k = 0..nbytes-1.
  - Drive mem_address=addr+k, mem_size=00, mem_sz_ex=0, mem_data_in={24'b0, wdata[8k+7:8k]}, mem_wr_en=req_we.
  - Load: mem_data_out[7:0] goes into assembly byte k.
  - After the last byte, extend the assembled value per req_size/req_sext (half: bit 15; word: none).
- RESP: resp_valid=1 for exactly one cycle; resp_rdata/resp_err valid. Return to IDLE next cycle.
- Memory-side outputs outside ACCESS: mem_wr_en=0, other mem_* hold the last value.
- Outputs are registered.

## Timing
- Reset (rst=0 at posedge) forces IDLE and clears k and the assembly register. All outputs take their reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_address=0, mem_data_in=0, mem_size=00, mem_sz_ex=0.
- The memory writes on the negedge inside an ACCESS cycle. Read data is sampled at the posedge ending that cycle.
- Latency from the accepting posedge to resp_valid high:
  - aligned: 2 cycles
  - split: nbytes+1 cycles
  - error: 1 cycle
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP; throughput is at most 1 per 3 cycles.
- req_valid while req_ready=0 is ignored. The core must hold the request until acceptance.
- Reset mid-ACCESS: abort immediately; mem_wr_en=0 from that cycle on; no response. Bytes already written by a split store stay written.
- A store to the last bytes (end = MEM_BYTES) is legal. end = MEM_BYTES+1 is an error.

## Test plan
- Aligned word store 0xDEADBEEF at addr 16, then word load at addr 16 -> one mem_wr_en cycle, resp_rdata=0xDEADBEEF, load response 2 cycles after acceptance.
- Preload mem[5]=0x34, mem[6]=0x85. Half load at addr 5 -> 2 byte accesses; sext=1 gives 0xFFFF8534, sext=0 gives 0x00008534, resp_valid 3 cycles after acceptance.
- Misaligned word store 0x11223344 at addr 13 -> 4 byte writes: 44@13, 33@14, 22@15, 11@16. A word load at 13 returns 0x11223344.
- Word access at addr 126 (MEM_BYTES=128), and req_size=11 at addr 0 -> resp_err=1 one cycle after acceptance, resp_rdata=0, mem_wr_en never asserted.
- SPLIT_MISALIGNED=0, half load at addr 3 -> resp_err=1, no memory cycle.
- Reset asserted during byte 2 of the addr-13 split store -> mem_wr_en=0 from the reset cycle, no resp_valid, req_ready=1 after reset. Bytes 13 and 14 were written, bytes 15 and 16 were not.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the core and a byte-addressable
// data memory. Checks range, size and alignment, optionally splits
// misaligned accesses into byte cycles, assembles and extends read data,
// and returns a one-cycle response. All outputs are registered.
module mem_access_ctrl #(
    parameter int BUS_WIDTH        = 32,
    parameter int MEM_BYTES        = 128,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_sext,
    output logic                 resp_valid,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_data_in,
    output logic                 mem_wr_en,
    output logic [1:0]           mem_size,
    output logic                 mem_sz_ex,
    input  logic [BUS_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state_q;

    // Latched request
    logic                 we_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [1:0]           size_q;
    logic                 sext_q;
    logic                 split_q;
    logic [1:0]           last_k_q;

    // Split-access byte counter and read assembly
    logic [1:0]           k_q;
    logic [1:0]           k_nxt;
    logic [BUS_WIDTH-1:0] asm_q;
    logic [BUS_WIDTH-1:0] asm_d;

    // Registered outputs
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [BUS_WIDTH-1:0] resp_rdata_q;
    logic                 resp_err_q;
    logic [BUS_WIDTH-1:0] mem_address_q;
    logic [BUS_WIDTH-1:0] mem_data_in_q;
    logic                 mem_wr_en_q;
    logic [1:0]           mem_size_q;
    logic                 mem_sz_ex_q;

    // Request decode
    logic [2:0]           nbytes_d;
    logic [BUS_WIDTH:0]   end_d;
    logic                 misalign_d;
    logic                 err_d;

    // Byte k of the store data placed in lane 0, upper lanes zero.
    function automatic logic [BUS_WIDTH-1:0] lane_byte(input logic [BUS_WIDTH-1:0] w,
                                                       input logic [1:0]           k);
        logic [BUS_WIDTH-1:0] s;
        s = w >> {k, 3'b000};
        return {{(BUS_WIDTH-8){1'b0}}, s[7:0]};
    endfunction

    // Sign/zero extension of an assembled load value by access size.
    function automatic logic [BUS_WIDTH-1:0] extend_load(input logic [BUS_WIDTH-1:0] v,
                                                         input logic [1:0]           size,
                                                         input logic                 sext);
        logic [BUS_WIDTH-1:0] r;
        case (size)
            2'b00:   r = {{(BUS_WIDTH-8){sext & v[7]}}, v[7:0]};
            2'b01:   r = {{(BUS_WIDTH-16){sext & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Decode size, end address (one extra bit so it never wraps) and faults.
    always_comb begin
        case (req_size)
            2'b00:   nbytes_d = 3'd1;
            2'b01:   nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
        endcase
        end_d      = {1'b0, req_addr} + (BUS_WIDTH+1)'(nbytes_d);
        misalign_d = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        err_d      = (req_size == 2'b11) ||
                     (end_d > (BUS_WIDTH+1)'(MEM_BYTES)) ||
                     (misalign_d && !SPLIT_MISALIGNED);
    end

    // Merge the byte returned in the current split cycle into the assembly.
    always_comb begin
        asm_d = asm_q;
        asm_d[{k_q, 3'b000} +: 8] = mem_data_out[7:0];
        k_nxt = k_q + 2'd1;
    end

    // Control FSM with registered request/response and memory-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            k_q           <= 2'd0;
            asm_q         <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_size_q    <= 2'b00;
            mem_sz_ex_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        sext_q      <= req_sext;
                        split_q     <= misalign_d;
                        last_k_q    <= 2'(nbytes_d - 3'd1);
                        k_q         <= 2'd0;
                        asm_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (err_d) begin
                            // Faulted requests never touch the memory.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q       <= ACCESS;
                            mem_wr_en_q   <= req_we;
                            mem_address_q <= req_addr;
                            if (misalign_d) begin
                                mem_size_q    <= 2'b00;
                                mem_sz_ex_q   <= 1'b0;
                                mem_data_in_q <= lane_byte(req_wdata, 2'd0);
                            end else begin
                                mem_size_q    <= req_size;
                                mem_sz_ex_q   <= req_sext;
                                mem_data_in_q <= req_wdata;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (!split_q) begin
                        // Memory already extended an aligned load.
                        state_q      <= RESP;
                        mem_wr_en_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : mem_data_out;
                    end else if (k_q == last_k_q) begin
                        state_q      <= RESP;
                        mem_wr_en_q  <= 1'b0;
                        asm_q        <= asm_d;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : extend_load(asm_d, size_q, sext_q);
                    end else begin
                        k_q           <= k_nxt;
                        asm_q         <= asm_d;
                        mem_address_q <= addr_q + BUS_WIDTH'(k_nxt);
                        mem_data_in_q <= lane_byte(wdata_q, k_nxt);
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end

                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_wr_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_size    = mem_size_q;
    assign mem_sz_ex   = mem_sz_ex_q;

endmodule
